// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: four-way intersection phase sequencer with pedestrian walk and night blink
module traffic_phase_scheduler #(
  parameter int TICK_DIV    = 1000,
  parameter int T_GREEN     = 5000,
  parameter int T_YELLOW    = 1000,
  parameter int T_ALLRED    = 500,
  parameter int T_WALK      = 3000,
  parameter int T_MIN_GREEN = 1000,
  parameter int T_BLINK     = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       pulse,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic [2:0] phase,
  output logic       ped_wait
);
  typedef enum logic [2:0] {NSG, NSY, AR1, EWG, EWY, AR2, WALK, BLINK} state_t;
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int TW = $clog2(T_GREEN + T_YELLOW + T_ALLRED + T_WALK + T_BLINK + 1);
  state_t state_q, state_d, nxt;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] timer_q, timer_d, dur_m1;
  logic blink_q, blink_d, ped_q, ped_d, dir_q, dir_d;
  logic tick, green, leave;
  assign tick = pre_q == PW'(TICK_DIV - 1);
  assign green = state_q == NSG || state_q == EWG;
  assign dur_m1 = green ? TW'(T_GREEN - 1) :
                  (state_q == NSY || state_q == EWY) ? TW'(T_YELLOW - 1) :
                  state_q == WALK ? TW'(T_WALK - 1) : TW'(T_ALLRED - 1);
  assign leave = tick && (timer_q == dur_m1 || (green && ped_q && timer_q >= TW'(T_MIN_GREEN - 1)));
  assign nxt = state_q == NSG ? NSY :
               state_q == NSY ? AR1 :
               state_q == AR1 ? (ped_q ? WALK : EWG) :
               state_q == EWG ? EWY :
               state_q == EWY ? AR2 :
               state_q == AR2 ? (ped_q ? WALK : NSG) :
               (dir_q ? NSG : EWG);
  // next state, timers, request latch; mode outranks all timer and request conditions
  always_comb begin
    state_d = state_q;
    pre_d = tick ? '0 : pre_q + 1'b1;
    timer_d = tick ? timer_q + 1'b1 : timer_q;
    blink_d = blink_q;
    dir_d = dir_q;
    ped_d = ped_q | (pulse && state_q != WALK && state_q != BLINK);
    if (mode && state_q != BLINK) begin
      state_d = BLINK;
      blink_d = 1'b1;
      ped_d = 1'b0;
    end else if (state_q == BLINK) begin
      if (!mode) state_d = AR2;
      else if (tick && timer_q == TW'(T_BLINK - 1)) begin
        blink_d = ~blink_q;
        timer_d = '0;
      end
    end else if (leave) begin
      state_d = nxt;
      dir_d = nxt == WALK ? state_q == AR2 : dir_q;
    end
    if (state_d == WALK && state_q != WALK) ped_d = 1'b0;
    if (state_d != state_q) begin
      pre_d = '0;
      timer_d = '0;
    end
  end
  // state registers; reset parks the intersection in all-red
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AR2;
      pre_q <= '0;
      timer_q <= '0;
      blink_q <= 1'b0;
      ped_q <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      ped_q <= ped_d;
      dir_q <= dir_d;
    end
  end
  // lamp decode from registered state; yellow is red and green lit together
  always_comb begin
    g = 4'b0000;
    r = 4'b1111;
    case (state_q)
      NSG:     begin g = 4'b0001; r = 4'b1110; end
      NSY:     g = 4'b0001;
      EWG:     begin g = 4'b0010; r = 4'b1101; end
      EWY:     g = 4'b0010;
      WALK:    begin g = 4'b1100; r = 4'b0011; end
      BLINK:   begin g = {2'b00, blink_q, blink_q}; r = {2'b00, blink_q, blink_q}; end
      default: ;
    endcase
  end
  assign b = {3'b000, ped_q};
  assign phase = state_q;
  assign ped_wait = ped_q;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed phase-timing, pedestrian, night-mode and reset checks
module tb_traffic_phase_scheduler;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, pulse = 1'b0;
  logic [3:0] r, g, b;
  logic [2:0] phase;
  logic ped_wait;
  int checks = 0, failures = 0;

  traffic_phase_scheduler #(
    .TICK_DIV(4), .T_GREEN(8), .T_YELLOW(2), .T_ALLRED(1),
    .T_WALK(3), .T_MIN_GREEN(2), .T_BLINK(2)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .pulse(pulse),
    .r(r), .g(g), .b(b), .phase(phase), .ped_wait(ped_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // expect phase p with lamps rr/gg for n consecutive cycles, starting now
  task automatic ph(input string tag, input logic [2:0] p, input int n,
                    input logic [3:0] rr, input logic [3:0] gg);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".phase"}, 32'(phase), 32'(p));
      chk({tag, ".r"}, 32'(r), 32'(rr));
      chk({tag, ".g"}, 32'(g), 32'(gg));
      chk({tag, ".b_hi"}, 32'(b[3:1]), 32'd0);
      step(1);
    end
  endtask

  initial begin
    step(2);
    chk("rst.phase", 32'(phase), 32'd5);
    chk("rst.r", 32'(r), 32'hF);
    chk("rst.g", 32'(g), 32'h0);
    chk("rst.b", 32'(b), 32'h0);
    chk("rst.ped", 32'(ped_wait), 32'd0);
    rst = 1'b0;
    // plain cycle, no requests
    ph("c.ar2", 3'd5, 4, 4'hF, 4'h0);
    ph("c.nsg", 3'd0, 32, 4'hE, 4'h1);
    ph("c.nsy", 3'd1, 8, 4'hF, 4'h1);
    ph("c.ar1", 3'd2, 4, 4'hF, 4'h0);
    ph("c.ewg", 3'd3, 32, 4'hD, 4'h2);
    ph("c.ewy", 3'd4, 8, 4'hF, 4'h2);
    ph("c.ar2b", 3'd5, 4, 4'hF, 4'h0);
    // request at NSG cycle 10 -> early exit at cycle 12, walk, then EWG
    ph("p.nsg", 3'd0, 10, 4'hE, 4'h1);
    pulse = 1'b1;
    step(1);
    pulse = 1'b0;
    chk("p.ped", 32'(ped_wait), 32'd1);
    chk("p.b", 32'(b), 32'h1);
    chk("p.ph11", 32'(phase), 32'd0);
    step(1);
    ph("p.nsy", 3'd1, 8, 4'hF, 4'h1);
    ph("p.ar1", 3'd2, 4, 4'hF, 4'h0);
    chk("p.walk_ped", 32'(ped_wait), 32'd0);
    ph("p.walk", 3'd6, 12, 4'h3, 4'hC);
    ph("p.ewg", 3'd3, 32, 4'hD, 4'h2);
    ph("p.ewy", 3'd4, 8, 4'hF, 4'h2);
    ph("p.ar2", 3'd5, 4, 4'hF, 4'h0);
    // request at NSG cycle 1 -> minimum green boundary at cycle 8
    ph("m.nsg0", 3'd0, 1, 4'hE, 4'h1);
    pulse = 1'b1;
    step(1);
    pulse = 1'b0;
    ph("m.nsg", 3'd0, 6, 4'hE, 4'h1);
    ph("m.nsy", 3'd1, 8, 4'hF, 4'h1);
    ph("m.ar1", 3'd2, 3, 4'hF, 4'h0);
    // pulse on the walk-entry edge and mid-walk are both dropped
    pulse = 1'b1;
    step(1);
    pulse = 1'b0;
    chk("w.entry_ped", 32'(ped_wait), 32'd0);
    ph("w.walk0", 3'd6, 5, 4'h3, 4'hC);
    pulse = 1'b1;
    step(1);
    pulse = 1'b0;
    chk("w.mid_ped", 32'(ped_wait), 32'd0);
    ph("w.walk", 3'd6, 6, 4'h3, 4'hC);
    ph("w.ewg", 3'd3, 32, 4'hD, 4'h2);
    ph("w.ewy", 3'd4, 8, 4'hF, 4'h2);
    ph("w.ar2", 3'd5, 4, 4'hF, 4'h0);
    // night mode from mid-EWG
    ph("n.nsg", 3'd0, 32, 4'hE, 4'h1);
    ph("n.nsy", 3'd1, 8, 4'hF, 4'h1);
    ph("n.ar1", 3'd2, 4, 4'hF, 4'h0);
    ph("n.ewg", 3'd3, 10, 4'hD, 4'h2);
    mode = 1'b1;
    step(1);
    ph("n.on1", 3'd7, 8, 4'h3, 4'h3);
    pulse = 1'b1;
    ph("n.off1a", 3'd7, 1, 4'h0, 4'h0);
    pulse = 1'b0;
    chk("n.ped", 32'(ped_wait), 32'd0);
    ph("n.off1", 3'd7, 7, 4'h0, 4'h0);
    ph("n.on2", 3'd7, 8, 4'h3, 4'h3);
    ph("n.off2", 3'd7, 3, 4'h0, 4'h0);
    mode = 1'b0;
    step(1);
    ph("n.ar2", 3'd5, 4, 4'hF, 4'h0);
    // reset mid-walk takes effect immediately
    pulse = 1'b1;
    ph("r.nsg0", 3'd0, 1, 4'hE, 4'h1);
    pulse = 1'b0;
    ph("r.nsg", 3'd0, 7, 4'hE, 4'h1);
    ph("r.nsy", 3'd1, 8, 4'hF, 4'h1);
    ph("r.ar1", 3'd2, 4, 4'hF, 4'h0);
    ph("r.walk", 3'd6, 5, 4'h3, 4'hC);
    rst = 1'b1;
    #1;
    chk("r.phase", 32'(phase), 32'd5);
    chk("r.r", 32'(r), 32'hF);
    chk("r.g", 32'(g), 32'h0);
    chk("r.b", 32'(b), 32'h0);
    chk("r.ped", 32'(ped_wait), 32'd0);
    step(2);
    rst = 1'b0;
    ph("r.ar2", 3'd5, 4, 4'hF, 4'h0);
    ph("r.nsg2", 3'd0, 2, 4'hE, 4'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
